// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and byte-mask helper for the LSU memory master
//
// Contents:
//   SZ_B / SZ_H / SZ_W  access size encodings (3 is reserved)
//   state_t             master FSM states
//   size_mask(size)     unshifted byte-enable pattern for a size; the reserved size maps to a full word
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        return size == SZ_B ? 4'b0001 : size == SZ_H ? 4'b0011 : 4'b1111;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: right-aligns a RAM read word to the byte offset and sign/zero-extends it to the access size
//
// Ports:
//   rdata  in   DATA_W        raw word from RAM
//   off    in   log2(DATA_W/8) byte offset inside the word
//   size   in   2             access size (SZ_B/SZ_H/SZ_W; reserved size treated as word)
//   uns    in   1             zero-extend when 1, sign-extend when 0
//   data   out  DATA_W        aligned, extended load result
module lsu_load_align import lsu_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             rdata,
    input  logic [$clog2(DATA_W/8)-1:0]   off,
    input  logic [1:0]                    size,
    input  logic                          uns,
    output logic [DATA_W-1:0]             data
);

    logic [DATA_W-1:0] rd;

    assign rd = rdata >> {off, 3'b000};

    always_comb data = size == SZ_B ? {{(DATA_W-8){~uns & rd[7]}}, rd[7:0]}
                     : size == SZ_H ? {{(DATA_W-16){~uns & rd[15]}}, rd[15:0]}
                     : rd;

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator between the execute stage and the data RAM
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses and the reserved
// size without touching RAM (respErr=1, respRdata=0). Without it respErr is constant 0 and misaligned
// accesses go out with a truncated mask/shift.
//
// Ports:
//   clock, reset                 posedge clock, asynchronous active-high reset
//   reqValid/reqReady            request handshake (reqReady high only while idle)
//   reqWrite, reqAddr, reqWdata  store flag, byte address, LSB-aligned store data
//   reqSize, reqUnsigned         0=byte 1=half 2=word 3=reserved; zero-extend loads when set
//   respValid/respReady          response handshake, response held until accepted
//   respRdata, respErr           extended load data (0 for stores), access error
//   memValid, memWriteEnable     one-cycle RAM strobe and write qualifier
//   memWriteAddr, memReadAddr    word-aligned address
//   memWriteData, memWriteMask   lane-shifted store data and byte mask
//   memReadData                  registered RAM read data
module lsu_mem_master import lsu_pkg::*; #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_W-1:0]     reqAddr,
    input  logic [DATA_W-1:0]     reqWdata,
    input  logic [1:0]            reqSize,
    input  logic                  reqUnsigned,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [DATA_W-1:0]     respRdata,
    output logic                  respErr,
    output logic                  memValid,
    output logic                  memWriteEnable,
    output logic [ADDR_W-1:0]     memWriteAddr,
    output logic [ADDR_W-1:0]     memReadAddr,
    output logic [DATA_W-1:0]     memWriteData,
    output logic [DATA_W/8-1:0]   memWriteMask,
    input  logic [DATA_W-1:0]     memReadData
);

    localparam int MW = DATA_W / 8;
    localparam int OW = $clog2(MW);
    localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [OW-1:0]     off, off_q, off_n;
    logic [1:0]        size_q, size_n;
    logic              uns_q, uns_n, write_q, write_n, err_q, err_n, bad;
    logic              req_ready_n, resp_valid_n, resp_err_n, mem_valid_n, mem_we_n;
    logic [DATA_W-1:0] resp_rdata_n, wdata_n, load_data;
    logic [ADDR_W-1:0] addr_n;
    logic [MW-1:0]     mask_n;

    assign off         = reqAddr[OW-1:0];
    assign memReadAddr = memWriteAddr;

`ifdef LSU_MISALIGN_CHECK_EN
    assign bad = reqSize == 2'd3 || (reqSize == SZ_H && reqAddr[0]) || (reqSize == SZ_W && off != '0);
`else
    assign bad = 1'b0;
`endif

    lsu_load_align #(.DATA_W(DATA_W)) u_align (
        .rdata (memReadData),
        .off   (off_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (load_data)
    );

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        off_n        = off_q;
        size_n       = size_q;
        uns_n        = uns_q;
        write_n      = write_q;
        err_n        = err_q;
        req_ready_n  = reqReady;
        resp_valid_n = respValid;
        resp_rdata_n = respRdata;
        resp_err_n   = respErr;
        mem_valid_n  = memValid;
        mem_we_n     = memWriteEnable;
        addr_n       = memWriteAddr;
        wdata_n      = memWriteData;
        mask_n       = memWriteMask;
        case (state)
            S_IDLE: if (reqValid) begin
                state_n     = S_ISSUE;
                req_ready_n = 1'b0;
                mem_valid_n = ~bad;
                mem_we_n    = reqWrite & ~bad;
                addr_n      = {reqAddr[ADDR_W-1:OW], OW'(0)};
                wdata_n     = reqWdata << {off, 3'b000};
                mask_n      = MW'(size_mask(reqSize)) << off;
                off_n       = off;
                size_n      = reqSize;
                uns_n       = reqUnsigned;
                write_n     = reqWrite;
                err_n       = bad;
            end
            // Rejected accesses skip the RAM wait and answer straight away.
            S_ISSUE: begin
                mem_valid_n  = 1'b0;
                mem_we_n     = 1'b0;
                state_n      = err_q ? S_RESP : S_WAIT;
                cnt_n        = CW'(MEM_LATENCY - 1);
                resp_valid_n = err_q;
                resp_err_n   = err_q;
                resp_rdata_n = '0;
            end
            S_WAIT: if (cnt == '0) begin
                state_n      = S_RESP;
                resp_valid_n = 1'b1;
                resp_rdata_n = write_q ? '0 : load_data;
            end else begin
                cnt_n = cnt - 1'b1;
            end
            S_RESP: if (respReady) begin
                state_n      = S_IDLE;
                resp_valid_n = 1'b0;
                resp_err_n   = 1'b0;
                req_ready_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            off_q          <= '0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            write_q        <= 1'b0;
            err_q          <= 1'b0;
            reqReady       <= 1'b1;
            respValid      <= 1'b0;
            respRdata      <= '0;
            respErr        <= 1'b0;
            memValid       <= 1'b0;
            memWriteEnable <= 1'b0;
            memWriteAddr   <= '0;
            memWriteData   <= '0;
            memWriteMask   <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            off_q          <= off_n;
            size_q         <= size_n;
            uns_q          <= uns_n;
            write_q        <= write_n;
            err_q          <= err_n;
            reqReady       <= req_ready_n;
            respValid      <= resp_valid_n;
            respRdata      <= resp_rdata_n;
            respErr        <= resp_err_n;
            memValid       <= mem_valid_n;
            memWriteEnable <= mem_we_n;
            memWriteAddr   <= addr_n;
            memWriteData   <= wdata_n;
            memWriteMask   <= mask_n;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: table-driven, directed and random checks of lsu_mem_master against a byte-level memory model
module tb_lsu_mem_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid = 1'b0, reqReady, reqWrite = 1'b0, reqUnsigned = 1'b0;
    logic [31:0] reqAddr = '0, reqWdata = '0;
    logic [1:0]  reqSize = '0;
    logic        respValid, respReady = 1'b0, respErr;
    logic [31:0] respRdata;
    logic        memValid, memWriteEnable;
    logic [31:0] memWriteAddr, memReadAddr, memWriteData;
    logic [3:0]  memWriteMask;
    logic [31:0] memReadData = '0;

    int checks = 0;
    int fails  = 0;

    logic [31:0] ram    [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];
    logic [31:0] ram_w;

    always #5 clock = ~clock;

    lsu_mem_master dut (
        .clock          (clock),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqAddr        (reqAddr),
        .reqWdata       (reqWdata),
        .reqSize        (reqSize),
        .reqUnsigned    (reqUnsigned),
        .respValid      (respValid),
        .respReady      (respReady),
        .respRdata      (respRdata),
        .respErr        (respErr),
        .memValid       (memValid),
        .memWriteEnable (memWriteEnable),
        .memWriteAddr   (memWriteAddr),
        .memReadAddr    (memReadAddr),
        .memWriteData   (memWriteData),
        .memWriteMask   (memWriteMask),
        .memReadData    (memReadData)
    );

    // Registered RAM: one cycle of read latency, returns 0 when not strobed.
    always @(posedge clock) begin
        if (memValid) begin
            ram_w = ram.exists(memReadAddr) ? ram[memReadAddr] : 32'h0;
            memReadData <= ram_w;
            if (memWriteEnable) begin
                ram_w = ram.exists(memWriteAddr) ? ram[memWriteAddr] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (memWriteMask[i]) ram_w[8*i +: 8] = memWriteData[8*i +: 8];
                ram[memWriteAddr] = ram_w;
            end
        end else begin
            memReadData <= 32'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        ram[a]    = d;
        shadow[a] = d;
    endtask

    // One full transaction with the model's expectations computed from byte offsets and access width.
    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input logic u, input int hold,
                       output logic [31:0] got_rd, output logic [3:0] got_mask, output logic got_err);
        logic [31:0] ea, word, v, lanes, ewd, erd;
        logic [3:0]  em;
        logic        eerr;
        int          off, nb;
        off  = int'(a[1:0]);
        nb   = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        ea   = a & 32'hFFFF_FFFC;
        em   = '0;
        for (int i = off; i < off + nb && i < 4; i++) em[i] = 1'b1;
        ewd  = d << (8 * off);
        eerr = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        eerr = sz == 2'd3 || (off % nb) != 0;
`endif
        word = shadow.exists(ea) ? shadow[ea] : 32'h0;
        v    = word >> (8 * off);
        if (nb < 4) begin
            lanes = (32'h1 << (8 * nb)) - 32'h1;
            v     = v & lanes;
            if (!u && v[8*nb-1]) v = v | ~lanes;
        end
        erd = (w || eerr) ? 32'h0 : v;
        chk("idle_ready", reqReady, 1);
        reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWdata = d; reqSize = sz; reqUnsigned = u;
        tick;
        reqValid = 1'b0;
        chk("busy_ready", reqReady, 0);
        chk("issue_memvalid", memValid, !eerr);
        got_mask = memWriteMask;
        if (!eerr) begin
            chk("issue_we", memWriteEnable, w);
            chk("issue_raddr", memReadAddr, ea);
            chk("issue_waddr", memWriteAddr, ea);
            chk("issue_mask", memWriteMask, em);
            chk("issue_wdata", memWriteData, ewd);
            if (w) begin
                word = shadow.exists(ea) ? shadow[ea] : 32'h0;
                for (int i = 0; i < 4; i++) if (em[i]) word[8*i +: 8] = ewd[8*i +: 8];
                shadow[ea] = word;
            end
            tick;
            chk("wait_memvalid", memValid, 0);
            chk("wait_resp", respValid, 0);
        end
        tick;
        chk("resp_valid", respValid, 1);
        chk("resp_rdata", respRdata, erd);
        chk("resp_err", respErr, eerr);
        got_rd  = respRdata;
        got_err = respErr;
        for (int i = 0; i < hold; i++) begin
            tick;
            chk("hold_valid", respValid, 1);
            chk("hold_rdata", respRdata, got_rd);
            chk("hold_ready", reqReady, 0);
            chk("hold_memvalid", memValid, 0);
        end
        respReady = 1'b1;
        tick;
        respReady = 1'b0;
        chk("resp_drop", respValid, 0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic        u;
        logic        pk;
        logic [31:0] init;
        logic [31:0] exp_rd;
        logic [3:0]  exp_mask;
        int          hold;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        logic [31:0] rd;
        logic [3:0]  mk;
        logic        er;
        tbl[0] = '{1'b0, 32'h8000_0004, 32'h0,         2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 0};
        tbl[1] = '{1'b0, 32'h8000_0003, 32'h0,         2'd0, 1'b0, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80, 4'b1000, 0};
        tbl[2] = '{1'b0, 32'h8000_0003, 32'h0,         2'd0, 1'b1, 1'b0, 32'h0,         32'h0000_0080, 4'b1000, 1};
        tbl[3] = '{1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'd1, 1'b0, 1'b1, 32'h1111_1111, 32'h0,         4'b1100, 0};
        tbl[4] = '{1'b0, 32'h8000_0000, 32'h0,         2'd2, 1'b0, 1'b0, 32'h0,         32'hABCD_1111, 4'b1111, 5};
        tbl[5] = '{1'b0, 32'h8000_0010, 32'h0,         2'd1, 1'b0, 1'b1, 32'h7FFF_8001, 32'hFFFF_8001, 4'b0011, 0};

        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_reqready", reqReady, 1);
        chk("rst_memvalid", memValid, 0);
        chk("rst_respvalid", respValid, 0);
        chk("rst_rdata", respRdata, 0);
        chk("rst_mask", memWriteMask, 0);
        chk("rst_err", respErr, 0);
        @(negedge clock) reset = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].pk) poke(tbl[i].a & 32'hFFFF_FFFC, tbl[i].init);
            run(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].u, tbl[i].hold, rd, mk, er);
            chk("tbl_rdata", rd, tbl[i].exp_rd);
            chk("tbl_mask", mk, tbl[i].exp_mask);
        end

        poke(32'h8000_0020, 32'hCAFE_F00D);
        run(1'b0, 32'h8000_0022, 32'h0, 2'd2, 1'b0, 0, rd, mk, er);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("misalign_err", er, 1);
`else
        chk("misalign_mask", mk, 4'b1100);
        chk("misalign_rdata", rd, 32'h0000_CAFE);
`endif

        // Reset while waiting for RAM data: transaction is dropped silently.
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h8000_0004; reqSize = 2'd2; reqUnsigned = 1'b0;
        tick;
        reqValid = 1'b0;
        tick;
        reset = 1'b1;
        #1;
        chk("midrst_memvalid", memValid, 0);
        chk("midrst_respvalid", respValid, 0);
        chk("midrst_reqready", reqReady, 1);
        chk("midrst_rdata", respRdata, 0);
        @(negedge clock) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("postrst_respvalid", respValid, 0);
            chk("postrst_memvalid", memValid, 0);
        end

        for (int n = 0; n < 60; n++) begin
            run(1'($urandom_range(0, 1)), 32'h8000_0000 + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
                $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), rd, mk, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
